coproc_uart_bridge: RTL and testbench
=====================================

COPROC_UART_BRIDGE -- requirements
Module: coproc_uart_bridge

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rx_data  input  8  received byte from UART receiver.
REQ-005 rx_valid  input  1  one-cycle strobe per received byte; no backpressure.
REQ-006 tx_data  output  8  byte to UART transmitter.
REQ-007 tx_valid  output  1  tx_data valid; byte transfers when tx_valid & tx_ready.
REQ-008 tx_ready  input  1  transmitter accepts byte.
REQ-009 cp_din  output  128  data word to coprocessor.
REQ-010 cp_din_valid  output  1  one-cycle strobe qualifying cp_din.
REQ-011 cp_control  output  5  control field to coprocessor; held between commands.
REQ-012 cp_dout  input  128  coprocessor result, combinational on cp_control.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 rx_dropped  output  1  sticky: a byte arrived while not accepting bytes.

Function
REQ-015 States: IDLE, RECV, ISSUE, CAPTURE, SEND; one-hot or binary encoding is allowed.
REQ-016 IDLE, rx_valid, rx_data[7]=1 (WRITE): cp_control <= rx_data[4:0]; byte counter <= 0; go to RECV.
REQ-017 IDLE, rx_valid, rx_data[7:6]=01 (READ): cp_control <= rx_data[4:0]; go to CAPTURE.
REQ-018 IDLE, rx_valid, rx_data[7:6]=00: byte ignored; stay in IDLE; rx_dropped unchanged.
REQ-019 RECV: each rx_valid byte k (k=0..15) is written to cp_din[8k+7:8k], little-endian; 4-bit counter increments.
REQ-020 RECV: on the 16th byte (counter=15), go to ISSUE; the counter wraps to 0.
REQ-021 ISSUE lasts exactly one cycle: cp_din_valid=1 with cp_din holding the assembled word, then IDLE.
REQ-022 Write latency: last payload byte sampled at cycle N gives cp_din_valid=1 during cycle N+1.
REQ-023 cp_din_valid is 0 in every state except ISSUE.
REQ-024 cp_din holds its last value outside RECV; it is not cleared between commands.
REQ-025 CAPTURE lasts exactly one cycle with cp_control stable; at its end, cp_dout is latched into a 128-bit tx buffer, counter <= 0, go to SEND.
REQ-026 SEND: tx_valid=1; tx_data = buffer[8k+7:8k] for counter k; it advances only on tx_valid & tx_ready.
REQ-027 SEND: after the handshake of byte 15, tx_valid deasserts the next cycle and the state returns to IDLE.
REQ-028 Read latency: READ byte at cycle N gives tx_valid=1 with byte 0 during cycle N+2.
REQ-029 tx_data and tx_valid remain stable while tx_valid & ~tx_ready (no retraction, no change).
REQ-030 rx_valid during ISSUE, CAPTURE or SEND: byte discarded; rx_dropped <= 1 until reset.
REQ-031 The tx buffer is unaffected by cp_dout changes during SEND.
REQ-032 No timeout: a partial RECV waits indefinitely for remaining bytes.

Reset
REQ-033 rst sampled high: state <= IDLE; counter <= 0; cp_din <= 0; cp_control <= 0; cp_din_valid <= 0; tx_valid <= 0; tx_data <= 0; busy <= 0; rx_dropped <= 0; tx buffer <= 0.
REQ-034 Reset mid-operation aborts the transfer: no cp_din_valid pulse and no further tx bytes; partial payload is discarded.
REQ-035 Reset dominates any simultaneous rx_valid or tx handshake in the same cycle.

Verification
REQ-036 WRITE 0x88, then bytes 0x01..0x10 -> cp_control=0x08; cp_din=0x100F0E0D0C0B0A090807060504030201; cp_din_valid high exactly one cycle after byte 0x10.
REQ-037 READ 0x48 with cp_dout=0x...00000017 (low word 23), tx_ready=1 -> tx bytes 0x17,0x00 x15; first tx_valid 2 cycles after command; busy low after 16th handshake.
REQ-038 READ with tx_ready toggling 1/0 each cycle -> 16 bytes in order, each held stable while stalled; cp_dout change mid-SEND not reflected.
REQ-039 Byte 0x05 in IDLE -> no state change, busy=0, rx_dropped=0; rx_valid during SEND -> rx_dropped=1, transmitted bytes unaffected.
REQ-040 WRITE 0x80 plus 7 payload bytes, then rst -> IDLE, cp_din=0, no cp_din_valid; subsequent full WRITE is assembled correctly from byte 0.
REQ-041 Back-to-back WRITE and READ with rx_valid every cycle -> both complete; the READ header arriving in the ISSUE cycle is dropped (rx_dropped=1); the header sent one cycle later is accepted.

Source files
------------

// File: rtl/coproc_uart_bridge_if.sv
// Bundles the UART byte streams and the coprocessor port into one interface.
// The bridge connects through the slave modport.
// The environment driving it connects through the master modport.
`timescale 1ns/1ps
interface coproc_uart_bridge_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [127:0] cp_din;
    logic         cp_din_valid;
    logic [4:0]   cp_control;
    logic [127:0] cp_dout;
    logic         busy;
    logic         rx_dropped;

    modport slave (
        input  rx_data, rx_valid, tx_ready, cp_dout,
        output tx_data, tx_valid, cp_din, cp_din_valid, cp_control, busy, rx_dropped
    );

    modport master (
        output rx_data, rx_valid, tx_ready, cp_dout,
        input  tx_data, tx_valid, cp_din, cp_din_valid, cp_control, busy, rx_dropped
    );
endinterface

// File: rtl/coproc_uart_bridge.sv
// UART-to-coprocessor bridge.
// A WRITE header (bit7=1) is followed by 16 payload bytes. The bytes are
// assembled little-endian into cp_din and issued with a one-cycle strobe.
// A READ header (bits7:6=01) captures cp_dout and streams it back to the
// transmitter as 16 bytes, least significant byte first.
`timescale 1ns/1ps
module coproc_uart_bridge (
    input  logic                      clk,
    input  logic                      rst,
    coproc_uart_bridge_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_ISSUE,
        S_CAPTURE,
        S_SEND
    } state_t;

    state_t       state_q;
    logic [3:0]   cnt_q;
    logic [3:0]   cnt_d;
    logic [127:0] cp_din_q;
    logic [4:0]   cp_control_q;
    logic         cp_din_valid_q;
    logic [127:0] txbuf_q;
    logic [7:0]   tx_data_q;
    logic         tx_valid_q;
    logic         busy_q;
    logic         rx_dropped_q;
    logic         tx_fire;

    // Byte index for the next payload or transmit byte; wraps 15 -> 0 naturally.
    assign cnt_d   = cnt_q + 4'd1;
    assign tx_fire = tx_valid_q & bus.tx_ready;

    // Command FSM; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            cp_din_q       <= '0;
            cp_control_q   <= 5'd0;
            cp_din_valid_q <= 1'b0;
            txbuf_q        <= '0;
            tx_data_q      <= 8'd0;
            tx_valid_q     <= 1'b0;
            busy_q         <= 1'b0;
            rx_dropped_q   <= 1'b0;
        end else begin
            cp_din_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_data[7]) begin
                            cp_control_q <= bus.rx_data[4:0];
                            cnt_q        <= 4'd0;
                            state_q      <= S_RECV;
                            busy_q       <= 1'b1;
                        end else if (bus.rx_data[6]) begin
                            cp_control_q <= bus.rx_data[4:0];
                            state_q      <= S_CAPTURE;
                            busy_q       <= 1'b1;
                        end
                        // Headers with bits7:6 = 00 are silently ignored.
                    end
                end
                S_RECV: begin
                    // No timeout: a partial payload waits here indefinitely.
                    if (bus.rx_valid) begin
                        cp_din_q[{cnt_q, 3'b000} +: 8] <= bus.rx_data;
                        cnt_q <= cnt_d;
                        if (cnt_q == 4'd15) begin
                            state_q        <= S_ISSUE;
                            cp_din_valid_q <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                S_CAPTURE: begin
                    // cp_control has been stable for this whole cycle.
                    // The coprocessor result is therefore settled.
                    txbuf_q    <= bus.cp_dout;
                    tx_data_q  <= bus.cp_dout[7:0];
                    tx_valid_q <= 1'b1;
                    cnt_q      <= 4'd0;
                    state_q    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_fire) begin
                        cnt_q <= cnt_d;
                        if (cnt_q == 4'd15) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_IDLE;
                            busy_q     <= 1'b0;
                        end else begin
                            tx_data_q <= txbuf_q[{cnt_d, 3'b000} +: 8];
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    tx_valid_q <= 1'b0;
                end
            endcase

            // Bytes arriving while the bridge cannot accept them are lost.
            // Record the loss until the next reset.
            if (bus.rx_valid &&
                (state_q == S_ISSUE || state_q == S_CAPTURE || state_q == S_SEND)) begin
                rx_dropped_q <= 1'b1;
            end
        end
    end

    assign bus.cp_din       = cp_din_q;
    assign bus.cp_control   = cp_control_q;
    assign bus.cp_din_valid = cp_din_valid_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.busy         = busy_q;
    assign bus.rx_dropped   = rx_dropped_q;

endmodule

// File: tb/tb_coproc_uart_bridge.sv
// Scoreboard bench for coproc_uart_bridge.
// Stimulus pushes the expected coprocessor writes and transmit bytes into queues.
// Monitors pop and compare those entries whenever the DUT presents them.
`timescale 1ns/1ps
module tb_coproc_uart_bridge;
    logic clk = 1'b0;
    logic rst = 1'b1;

    coproc_uart_bridge_if bus ();

    coproc_uart_bridge dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]   ctl;
        logic [127:0] din;
    } cp_exp_t;

    cp_exp_t     cp_q[$];
    logic [7:0]  tx_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [127:0] perturb = '0;

    // Coprocessor stand-in: the result is a pure function of cp_control.
    // Command 8 returns the hand value 0x17.
    function automatic logic [127:0] dout_model(input logic [4:0] c);
        logic [127:0] r;
        if (c == 5'h08) return 128'h17;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = {c[3:0], 4'h0} ^ 8'(k) ^ 8'h5A;
        return r;
    endfunction

    assign bus.cp_dout = dout_model(bus.cp_control) ^ perturb;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic write_cmd(input logic [7:0] hdr, input logic [127:0] payload);
        cp_exp_t e;
        e.ctl = hdr[4:0];
        e.din = payload;
        cp_q.push_back(e);
        send_byte(hdr);
        for (int k = 0; k < 16; k++) send_byte(payload[8*k +: 8]);
    endtask

    task automatic push_read(input logic [127:0] w);
        for (int k = 0; k < 16; k++) tx_q.push_back(w[8*k +: 8]);
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 200 && bus.busy; i++) tick();
        check({name, "_idle_timeout"}, {127'd0, bus.busy}, 128'd0);
    endtask

    // Monitor for coprocessor writes and transmit handshakes, sampled on the falling edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.cp_din_valid) begin
                if (cp_q.size() == 0) begin
                    check("unexpected_cp_din_valid", 128'd1, 128'd0);
                end else begin
                    cp_exp_t e;
                    e = cp_q.pop_front();
                    check("cp_din", bus.cp_din, e.din);
                    check("cp_control", {123'd0, bus.cp_control}, {123'd0, e.ctl});
                end
            end
            if (prev_stall) begin
                check("stall_tx_valid", {127'd0, bus.tx_valid}, 128'd1);
                check("stall_tx_data", {120'd0, bus.tx_data}, {120'd0, prev_data});
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (tx_q.size() == 0) begin
                    check("unexpected_tx_byte", {120'd0, bus.tx_data}, 128'hFFFF);
                end else begin
                    logic [7:0] b;
                    b = tx_q.pop_front();
                    check("tx_byte", {120'd0, bus.tx_data}, {120'd0, b});
                end
            end
            prev_stall = bus.tx_valid & ~bus.tx_ready;
            prev_data  = bus.tx_data;
        end
    end

    initial begin
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // Reset state.
        check("rst_busy", {127'd0, bus.busy}, 128'd0);
        check("rst_tx_valid", {127'd0, bus.tx_valid}, 128'd0);
        check("rst_tx_data", {120'd0, bus.tx_data}, 128'd0);
        check("rst_cp_din", bus.cp_din, 128'd0);
        check("rst_cp_control", {123'd0, bus.cp_control}, 128'd0);
        check("rst_cp_din_valid", {127'd0, bus.cp_din_valid}, 128'd0);
        check("rst_rx_dropped", {127'd0, bus.rx_dropped}, 128'd0);

        // An ignored header leaves the bridge idle.
        send_byte(8'h05);
        check("ign_busy", {127'd0, bus.busy}, 128'd0);
        check("ign_rx_dropped", {127'd0, bus.rx_dropped}, 128'd0);

        // WRITE 0x88 with payload bytes 01..10.
        write_cmd(8'h88, 128'h100F0E0D0C0B0A090807060504030201);
        check("wr_strobe_n1", {127'd0, bus.cp_din_valid}, 128'd1);
        tick();
        check("wr_strobe_n2", {127'd0, bus.cp_din_valid}, 128'd0);
        check("wr_busy_after", {127'd0, bus.busy}, 128'd0);

        // READ 0x48 with tx_ready high; the bytes are 0x17 then fifteen 0x00.
        tx_q.push_back(8'h17);
        for (int k = 0; k < 15; k++) tx_q.push_back(8'h00);
        send_byte(8'h48);
        check("rd_tx_valid_n1", {127'd0, bus.tx_valid}, 128'd0);
        check("rd_busy_n1", {127'd0, bus.busy}, 128'd1);
        tick();
        check("rd_tx_valid_n2", {127'd0, bus.tx_valid}, 128'd1);
        for (int k = 0; k < 15; k++) tick();
        check("rd_busy_before_last", {127'd0, bus.busy}, 128'd1);
        tick();
        check("rd_busy_after_last", {127'd0, bus.busy}, 128'd0);
        check("rd_tx_valid_after_last", {127'd0, bus.tx_valid}, 128'd0);
        check("cp_din_held", bus.cp_din, 128'h100F0E0D0C0B0A090807060504030201);

        // READ 0x43 with tx_ready toggling.
        // cp_dout changes mid-SEND and a byte arrives mid-SEND.
        push_read(dout_model(5'h03));
        send_byte(8'h43);
        begin
            int i;
            for (i = 0; i < 200; i++) begin
                bus.tx_ready = i[0];
                bus.rx_valid = (i == 7);
                bus.rx_data  = 8'h99;
                if (i == 5) perturb = {128{1'b1}};
                tick();
                if (!bus.busy) break;
            end
            bus.rx_valid = 1'b0;
            bus.tx_ready = 1'b1;
            perturb = '0;
        end
        wait_idle("toggle");
        check("send_rx_dropped", {127'd0, bus.rx_dropped}, 128'd1);
        check("toggle_tx_q_empty", 128'(tx_q.size()), 128'd0);

        // A partial WRITE aborted by reset, then a full WRITE.
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst2_rx_dropped", {127'd0, bus.rx_dropped}, 128'd0);
        send_byte(8'h80);
        for (int k = 0; k < 7; k++) send_byte(8'hA0 + 8'(k));
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", {127'd0, bus.busy}, 128'd0);
        check("abort_cp_din", bus.cp_din, 128'd0);
        tick();
        write_cmd(8'h81, 128'hFFFEFDFCFBFAF9F8F7F6F5F4F3F2F1F0);
        tick();

        // Back-to-back traffic: WRITE, then a READ header landing in ISSUE
        // (dropped), then the same header one cycle later (accepted).
        rst = 1'b1; tick(); rst = 1'b0;
        push_read(dout_model(5'h04));
        write_cmd(8'h92, 128'h2F2E2D2C2B2A29282726252423222120);
        send_byte(8'h44);
        send_byte(8'h44);
        wait_idle("b2b");
        check("b2b_rx_dropped", {127'd0, bus.rx_dropped}, 128'd1);
        check("b2b_cp_control", {123'd0, bus.cp_control}, 128'h4);
        tick(); tick();

        check("final_cp_q_empty", 128'(cp_q.size()), 128'd0);
        check("final_tx_q_empty", 128'(tx_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
